// File: rtl/fetch_seq.sv
// Instruction fetch/sequencer: holds PC, fetches over req/ack, latches IR, drives the EXEC phase.
// Optional single-step input step_i is enabled by defining FETCH_STEP_EN.
module fetch_seq #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
`ifdef FETCH_STEP_EN
    input  logic              step_i,
`endif
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [OP_W-1:0]   op_o,
    output logic [ADDR_W-1:0] operand_o,
    output logic              exec_o,
    input  logic              exec_wait_i,
    input  logic              jmp_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nx;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   w_ir_nx;
    logic                w_start;

`ifdef FETCH_STEP_EN
    // A step is only accepted on a low-to-high transition, so holding step_i runs one instruction.
    logic r_step_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_step_d <= 1'b0;
        else       r_step_d <= step_i;
    end

    assign w_start = run_i | (step_i & ~r_step_d);
`else
    assign w_start = run_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_ir    <= w_ir_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_ir_nx    = r_ir;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    w_ir_nx    = imem_data_i;
                    w_state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!exec_wait_i) begin
                    w_pc_nx    = jmp_i ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(1);
                    w_state_nx = run_i ? S_FETCH : S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // All outputs are decoded from registers only; no combinational input-to-output path.
    assign imem_req_o  = (r_state == S_FETCH);
    assign imem_addr_o = r_pc;
    assign exec_o      = (r_state == S_EXEC);
    assign busy_o      = (r_state != S_IDLE);
    assign op_o        = r_ir[DATA_W-1 -: OP_W];
    assign operand_o   = r_ir[ADDR_W-1:0];
    assign pc_o        = r_pc;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: cycle vector table plus hand-written stall, reset and step sequences.
module tb_fetch_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] data = '0;
    logic       wt = 1'b0;
    logic       jmp = 1'b0;
    logic       req;
    logic [4:0] addr;
    logic [2:0] op;
    logic [4:0] opnd;
    logic       exe;
    logic [4:0] pc;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_seq #(.DATA_W(8), .OP_W(3), .ADDR_W(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_i       (run),
`ifdef FETCH_STEP_EN
        .step_i      (step),
`endif
        .imem_req_o  (req),
        .imem_addr_o (addr),
        .imem_ack_i  (ack),
        .imem_data_i (data),
        .op_o        (op),
        .operand_o   (opnd),
        .exec_o      (exe),
        .exec_wait_i (wt),
        .jmp_i       (jmp),
        .pc_o        (pc),
        .busy_o      (busy)
    );

    typedef struct {
        logic       run, ack;
        logic [7:0] data;
        logic       wt, jmp;
        logic       req;
        logic [4:0] addr;
        logic       exe;
        logic [2:0] op;
        logic [4:0] opnd, pc;
        logic       busy;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t v(input logic r, input logic a, input logic [7:0] d,
                               input logic w, input logic j, input logic rq,
                               input logic [4:0] ad, input logic ex, input logic [2:0] o,
                               input logic [4:0] od, input logic [4:0] p, input logic b);
        vec_t t;
        t.run = r; t.ack = a; t.data = d; t.wt = w; t.jmp = j;
        t.req = rq; t.addr = ad; t.exe = ex; t.op = o; t.opnd = od; t.pc = p; t.busy = b;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        //         run   ack   data   wt    jmp  | req   addr   exe   op    opnd    pc     busy
        vt[0]  = v(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 3'd0, 5'd0,  5'd0,  1'b0);
        vt[1]  = v(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 3'd0, 5'd0,  5'd0,  1'b1);
        vt[2]  = v(1'b1, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 3'd2, 5'd5,  5'd0,  1'b1);
        vt[3]  = v(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 3'd2, 5'd5,  5'd1,  1'b1);
        vt[4]  = v(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 3'd0, 5'd2,  5'd1,  1'b1);
        vt[5]  = v(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2,  1'b0, 3'd0, 5'd2,  5'd2,  1'b1);
        vt[6]  = v(1'b1, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 5'd2,  1'b1, 3'd4, 5'd26, 5'd2,  1'b1);
        vt[7]  = v(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd26, 1'b0, 3'd4, 5'd26, 5'd26, 1'b1);
        vt[8]  = v(1'b1, 1'b1, 8'h9A, 1'b0, 1'b1, 1'b0, 5'd26, 1'b1, 3'd4, 5'd26, 5'd26, 1'b1);
        vt[9]  = v(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd27, 1'b0, 3'd4, 5'd26, 5'd27, 1'b1);
        vt[10] = v(1'b1, 1'b1, 8'hBF, 1'b0, 1'b0, 1'b0, 5'd27, 1'b1, 3'd5, 5'd31, 5'd27, 1'b1);
        vt[11] = v(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 3'd5, 5'd31, 5'd31, 1'b1);
        vt[12] = v(1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 3'd1, 5'd0,  5'd31, 1'b1);
        vt[13] = v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 3'd1, 5'd0,  5'd0,  1'b0);
        vt[14] = v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 3'd1, 5'd0,  5'd0,  1'b0);
        vt[15] = v(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 3'd1, 5'd0,  5'd0,  1'b0);
        vt[16] = v(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 3'd1, 5'd0,  5'd0,  1'b1);
        vt[17] = v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 3'd1, 5'd0,  5'd0,  1'b1);
        vt[18] = v(1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 3'd3, 5'd1,  5'd0,  1'b1);
        vt[19] = v(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 3'd3, 5'd1,  5'd0,  1'b1);
        vt[20] = v(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1,  1'b0, 3'd3, 5'd1,  5'd1,  1'b0);

        // reset state
        #2;
        chk("rst_req", 32'(req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pc", 32'(pc), 0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            run = vt[i].run; ack = vt[i].ack; data = vt[i].data; wt = vt[i].wt; jmp = vt[i].jmp;
            tick();
            chk($sformatf("v%0d_req", i),  32'(req),  32'(vt[i].req));
            chk($sformatf("v%0d_addr", i), 32'(addr), 32'(vt[i].addr));
            chk($sformatf("v%0d_exec", i), 32'(exe),  32'(vt[i].exe));
            chk($sformatf("v%0d_op", i),   32'(op),   32'(vt[i].op));
            chk($sformatf("v%0d_opnd", i), 32'(opnd), 32'(vt[i].opnd));
            chk($sformatf("v%0d_pc", i),   32'(pc),   32'(vt[i].pc));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
        end

        // stalls: ack after 3 idle FETCH cycles, then 2 exec wait cycles (IDLE, PC=1 here)
        run = 1'b1; ack = 1'b0; wt = 1'b0; jmp = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_req", 32'(req), 1);
            chk("stall_addr", 32'(addr), 1);
            ack = (i == 3); data = 8'h45;
            tick();
        end
        ack = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stall_exec", 32'(exe), 1);
            chk("stall_op", 32'(op), 2);
            chk("stall_pc", 32'(pc), 1);
            wt = (j < 2);
            tick();
        end
        wt = 1'b0;
        chk("stall_exec_end", 32'(exe), 0);
        chk("stall_req_next", 32'(req), 1);
        chk("stall_pc_adv", 32'(pc), 2);

        // walk to EXEC at PC=7, then reset mid-EXEC
        ack = 1'b1; data = 8'h07; tick();
        ack = 1'b0; jmp = 1'b1; tick();
        chk("j7_addr", 32'(addr), 7);
        jmp = 1'b0; ack = 1'b1; data = 8'h12; tick();
        ack = 1'b0; wt = 1'b1; tick();
        chk("pre_rst_exec", 32'(exe), 1);
        chk("pre_rst_pc", 32'(pc), 7);
        #2;
        rst = 1'b1; ack = 1'b1; data = 8'hFF;
        #1;
        chk("mid_rst_exec", 32'(exe), 0);
        chk("mid_rst_req", 32'(req), 0);
        chk("mid_rst_pc", 32'(pc), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_op", 32'(op), 0);
        chk("mid_rst_opnd", 32'(opnd), 0);
        tick();
        chk("hold_rst_pc", 32'(pc), 0);
        chk("hold_rst_busy", 32'(busy), 0);
        rst = 1'b0; run = 1'b0; ack = 1'b0; wt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", 32'(busy), 0);
            chk("post_rst_noreq", 32'(req), 0);
        end
        run = 1'b1; tick();
        chk("restart_req", 32'(req), 1);
        chk("restart_addr", 32'(addr), 0);
        run = 1'b0; ack = 1'b1; data = 8'h00; tick();
        ack = 1'b0; tick();
        chk("restart_idle", 32'(busy), 0);
        chk("restart_pc", 32'(pc), 1);

`ifdef FETCH_STEP_EN
        // single step: step held high for 10 cycles runs exactly one instruction
        rst = 1'b1; tick(); rst = 1'b0;
        run = 1'b0; ack = 1'b1; data = 8'h00; wt = 1'b0; jmp = 1'b0;
        step = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (exe) n++;
        end
        chk("step1_exec_cycles", 32'(n), 1);
        chk("step1_pc", 32'(pc), 1);
        chk("step1_idle", 32'(busy), 0);
        step = 1'b0; tick(); tick();
        step = 1'b1; tick();
        step = 1'b0;
        n = (exe) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (exe) n++;
        end
        chk("step2_exec_cycles", 32'(n), 1);
        chk("step2_pc", 32'(pc), 2);
        chk("step2_idle", 32'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
